seven_segment_bcd_display: RTL and testbench

Registered binary-to-decimal display driver for the board's seven-segment bank. It accepts a DATA_WIDTH-bit unsigned value through a valid/ready handshake and converts it serially with shift-add-3 (double dabble), one bit per clock. It then latches DIGITS decoded digit patterns plus the packed BCD. It supports optional leading-zero blanking and an overflow indication when the value exceeds DIGITS decimal places.

---
 rtl/seven_segment_bcd_display_if.sv | 25 ++
 rtl/seven_segment_bcd_display.sv | 137 +++++++++++++
 tb/tb_seven_segment_bcd_display.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_bcd_display_if.sv
// Value-in / display-out bundle of the seven-segment BCD driver.
// Handshake: a transfer happens on a rising clock edge where data_valid and ready are both 1; data_valid while ready is 0 is ignored.
interface seven_segment_bcd_display_if #(
    parameter int DATA_WIDTH = 20,
    parameter int DIGITS     = 6
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  blank_leading_zeros;
    logic                  ready;
    logic [DIGITS*7-1:0]   segment_pins;
    logic [DIGITS*4-1:0]   bcd_out;
    logic                  overflow;
    logic                  update_done;

    modport master (
        output data_in, data_valid, blank_leading_zeros,
        input  ready, segment_pins, bcd_out, overflow, update_done
    );

    modport slave (
        input  data_in, data_valid, blank_leading_zeros,
        output ready, segment_pins, bcd_out, overflow, update_done
    );
endinterface

// File: rtl/seven_segment_bcd_display.sv
// Serial double-dabble binary-to-BCD converter feeding registered seven-segment patterns.
// One bit is converted per clock, and the results are latched in a single cycle when the conversion ends.
module seven_segment_bcd_display #(
    parameter int DATA_WIDTH = 20,
    parameter int DIGITS     = 6,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    seven_segment_bcd_display_if.slave  bus,
    output logic [1:0]                  dbg_state
);
    localparam int INT_DIGITS = (DATA_WIDTH + 2) / 3;
    // The register is widened to DIGITS when the display has more places than the conversion needs.
    localparam int NDIG = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
    localparam int BW   = NDIG * 4;
    localparam int CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic AL = (ACTIVE_LOW != 0);
    localparam logic [6:0] DASH = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bcd_q;
    logic [BW-1:0]         adj;
    logic [CW-1:0]         cnt_q;
    logic                  blank_q;
    logic                  ovf_c;
    logic                  zero_run;
    logic [3:0]            dig;
    logic [6:0]            lit;
    logic [DIGITS*7-1:0]   seg_c;

    function automatic logic [6:0] lit_of(input logic [3:0] d);
        case (d)
            4'd0:    lit_of = 7'b0111111;
            4'd1:    lit_of = 7'b0000110;
            4'd2:    lit_of = 7'b1011011;
            4'd3:    lit_of = 7'b1001111;
            4'd4:    lit_of = 7'b1100110;
            4'd5:    lit_of = 7'b1101101;
            4'd6:    lit_of = 7'b1111101;
            4'd7:    lit_of = 7'b0000111;
            4'd8:    lit_of = 7'b1111111;
            4'd9:    lit_of = 7'b1101111;
            default: lit_of = 7'b0000000;
        endcase
    endfunction

    assign bus.ready = (state_q == IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.data_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // The digit patterns are computed from the finished BCD. They are registered only in LATCH.
    always_comb begin
        ovf_c    = 1'b0;
        seg_c    = '0;
        zero_run = 1'b1;
        dig      = '0;
        lit      = '0;
        for (int i = DIGITS; i < NDIG; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) ovf_c = 1'b1;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig      = bcd_q[i*4 +: 4];
            zero_run = zero_run & (dig == 4'd0);
            if (ovf_c)                          lit = DASH;
            else if (i > 0 && blank_q && zero_run) lit = 7'b0000000;
            else                                lit = lit_of(dig);
            seg_c[i*7 +: 7] = lit ^ {7{AL}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q          <= '0;
            bcd_q            <= '0;
            cnt_q            <= '0;
            blank_q          <= 1'b0;
            bus.segment_pins <= {(DIGITS*7){AL}};
            bus.bcd_out      <= '0;
            bus.overflow     <= 1'b0;
            bus.update_done  <= 1'b0;
        end else begin
            bus.update_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.data_valid) begin
                        shift_q <= bus.data_in;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        blank_q <= bus.blank_leading_zeros;
                    end
                end
                SHIFT: begin
                    bcd_q   <= {adj[BW-2:0], shift_q[DATA_WIDTH-1]};
                    shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                end
                LATCH: begin
                    bus.segment_pins <= seg_c;
                    bus.bcd_out      <= bcd_q[DIGITS*4-1:0];
                    bus.overflow     <= ovf_c;
                    bus.update_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seven_segment_bcd_display.sv
// Randomised bench for seven_segment_bcd_display at default parameters (20-bit input, 6 digits, active-low pins).
// Expected results come from a decimal-arithmetic model of the display.
module tb_seven_segment_bcd_display;
    localparam int DW = 20;
    localparam int DG = 6;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    seven_segment_bcd_display_if #(.DATA_WIDTH(DW), .DIGITS(DG)) bus ();

    seven_segment_bcd_display #(.DATA_WIDTH(DW), .DIGITS(DG), .ACTIVE_LOW(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;
    bit flood = 1'b0;
    logic [DG*4-1:0] exp_q[$];
    int unsigned cur_v;
    logic        cur_b;
    logic [DG*4-1:0] shown_bcd;
    logic [DG*7-1:0] shown_seg;
    logic            shown_ovf;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    function automatic logic [DG*4-1:0] model_bcd(input int unsigned v);
        logic [DG*4-1:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < DG; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v);
        return v >= 1000000;
    endfunction

    function automatic logic [DG*7-1:0] model_seg(input int unsigned v, input logic b);
        logic [DG*7-1:0] r;
        logic [6:0] lit;
        int unsigned t;
        int nd;
        t  = v;
        nd = 1;
        while (t >= 10) begin
            t = t / 10;
            nd++;
        end
        t = v;
        r = '0;
        for (int i = 0; i < DG; i++) begin
            if (model_ovf(v))          lit = 7'b1000000;
            else if (b && i >= nd)     lit = 7'b0000000;
            else                       lit = seg_tab[t % 10];
            r[i*7 +: 7] = ~lit;
            t = t / 10;
        end
        return r;
    endfunction

    task automatic set_shown_reset();
        shown_bcd = '0;
        shown_seg = '1;
        shown_ovf = 1'b0;
    endtask

    task automatic start(input int unsigned v, input logic b);
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_err++;
            $display("FAIL start_ready_timeout: ready=%b required=1", bus.ready);
        end
        bus.data_valid          = 1'b1;
        bus.data_in             = DW'(v);
        bus.blank_leading_zeros = b;
        cur_v = v;
        cur_b = b;
        exp_q.push_back(model_bcd(v));
        @(posedge clk);
        @(negedge clk);
        if (flood) begin
            bus.data_in = DW'(77);
        end else begin
            bus.data_valid = 1'b0;
            bus.data_in    = DW'($urandom_range(0, (1 << DW) - 1));
            bus.blank_leading_zeros = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input string tag);
        int lat;
        logic [DG*4-1:0] eb;
        logic [DG*7-1:0] es;
        logic            eo;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.update_done === 1'b1) break;
            n_vec++;
            if (bus.bcd_out !== shown_bcd || bus.segment_pins !== shown_seg || bus.overflow !== shown_ovf) begin
                n_err++;
                $display("FAIL %s_hold: bcd=%h seg=%b ovf=%b required bcd=%h seg=%b ovf=%b",
                         tag, bus.bcd_out, bus.segment_pins, bus.overflow, shown_bcd, shown_seg, shown_ovf);
            end
            n_vec++;
            if (bus.ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s_busy_ready: ready=%b required=0", tag, bus.ready);
            end
            if (flood) begin
                bus.data_valid = 1'b1;
                bus.data_in    = DW'(77);
            end
        end
        n_vec++;
        if (lat !== DW + 1) begin
            n_err++;
            $display("FAIL %s_latency: edges=%0d required=%0d", tag, lat, DW + 1);
        end
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : model_bcd(cur_v);
        es = model_seg(cur_v, cur_b);
        eo = model_ovf(cur_v);
        n_vec++;
        if (bus.bcd_out !== eb) begin
            n_err++;
            $display("FAIL %s_bcd: got=%h required=%h (value %0d)", tag, bus.bcd_out, eb, cur_v);
        end
        n_vec++;
        if (bus.overflow !== eo) begin
            n_err++;
            $display("FAIL %s_overflow: got=%b required=%b (value %0d)", tag, bus.overflow, eo, cur_v);
        end
        n_vec++;
        if (bus.segment_pins !== es) begin
            n_err++;
            $display("FAIL %s_segments: got=%b required=%b (value %0d blank %b)", tag, bus.segment_pins, es, cur_v, cur_b);
        end
        shown_bcd = eb;
        shown_seg = es;
        shown_ovf = eo;
    endtask

    task automatic check_pulse_end(input string tag);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.update_done !== 1'b0 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_pulse_end: update_done=%b ready=%b required 0/1", tag, bus.update_done, bus.ready);
        end
    endtask

    task automatic convert(input int unsigned v, input logic b, input string tag);
        start(v, b);
        wait_done(tag);
        check_pulse_end(tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in = DW'(5);
        bus.blank_leading_zeros = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_shown_reset();
        n_vec++;
        if (bus.bcd_out !== shown_bcd || bus.segment_pins !== shown_seg || bus.overflow !== 1'b0 ||
            bus.update_done !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_values: bcd=%h seg=%b ovf=%b done=%b state=%0d required 0/all-ones/0/0/0",
                     bus.bcd_out, bus.segment_pins, bus.overflow, bus.update_done, dbg_state);
        end
        reset = 1'b0;
        bus.data_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: ready=%b required=1", bus.ready);
        end
    endtask

    task automatic test_directed();
        convert(123456, 1'b0, "d123456");
        n_vec++;
        if (bus.segment_pins[41:35] !== 7'b1111001 || bus.segment_pins[6:0] !== 7'b0000010) begin
            n_err++;
            $display("FAIL d123456_pins: d5=%b d0=%b required 1111001/0000010",
                     bus.segment_pins[41:35], bus.segment_pins[6:0]);
        end
        convert(0, 1'b1, "zero_blank");
        n_vec++;
        if (bus.segment_pins !== {{5{7'b1111111}}, 7'b1000000}) begin
            n_err++;
            $display("FAIL zero_blank_pins: got=%b required d0=1000000 others 1111111", bus.segment_pins);
        end
        convert(1000000, 1'b0, "ovf");
        n_vec++;
        if (bus.segment_pins !== {6{7'b0111111}} || bus.bcd_out !== 24'h000000) begin
            n_err++;
            $display("FAIL ovf_dash: seg=%b bcd=%h required all 0111111, 000000", bus.segment_pins, bus.bcd_out);
        end
        convert(999999, 1'b0, "max6");
        convert(1048575, 1'b1, "max20");
        convert(100, 1'b1, "blank_mid_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            convert($urandom_range(0, (1 << DW) - 1), 1'($urandom_range(0, 1)), "rand");
        end
        for (int i = 0; i < 6; i++) begin
            convert($urandom_range(0, 9999), 1'b1, "rand_small");
        end
    endtask

    task automatic test_busy_ignored();
        flood = 1'b1;
        start(42, 1'b0);
        wait_done("busy42");
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.update_done !== 1'b0 || bus.ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_accept77: update_done=%b ready=%b required 0/0", bus.update_done, bus.ready);
        end
        flood = 1'b0;
        bus.data_valid = 1'b0;
        cur_v = 77;
        cur_b = 1'b0;
        exp_q.push_back(model_bcd(77));
        wait_done("busy77");
        check_pulse_end("busy77");
    endtask

    task automatic test_reset_mid_shift();
        int dones;
        start(555555, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        set_shown_reset();
        n_vec++;
        if (bus.bcd_out !== shown_bcd || bus.segment_pins !== shown_seg || bus.overflow !== 1'b0 ||
            bus.update_done !== 1'b0 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_values: bcd=%h seg=%b ovf=%b done=%b ready=%b",
                     bus.bcd_out, bus.segment_pins, bus.overflow, bus.update_done, bus.ready);
        end
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.update_done === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL midreset_no_done: pulses=%0d required=0", dones);
        end
        convert(7, 1'b1, "after_reset7");
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in = '0;
        bus.blank_leading_zeros = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_busy_ignored();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
